mult_unit: RTL and testbench



---
 rtl/mult_pkg.sv | 37 +++
 rtl/mult_iter.sv | 53 +++++
 rtl/mult_unit.sv | 143 ++++++++++++++
 tb/tb_mult_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the HI/LO multiply unit.
// Func encodings follow the MIPS SPECIAL and SPECIAL2 opcode tables.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIN
   } state_t;

   typedef enum logic [1:0] {
      MC_MULT,
      MC_MADD,
      MC_MSUB,
      MC_MUL
   } op_class_t;

   localparam int ITER_COUNT = 32;

   // SPECIAL class (MULOp low)
   localparam logic [5:0] FUNC_MTHI  = 6'h11;
   localparam logic [5:0] FUNC_MTLO  = 6'h13;
   localparam logic [5:0] FUNC_MULT  = 6'h18;
   localparam logic [5:0] FUNC_MULTU = 6'h19;
   // SPECIAL2 class (MULOp high)
   localparam logic [5:0] FUNC_MADD  = 6'h00;
   localparam logic [5:0] FUNC_MADDU = 6'h01;
   localparam logic [5:0] FUNC_MUL   = 6'h02;
   localparam logic [5:0] FUNC_MSUB  = 6'h04;
   localparam logic [5:0] FUNC_MSUBU = 6'h05;

   // 0x80000000 maps onto itself, which is exactly the unsigned magnitude.
   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/mult_iter.sv
// Unsigned shift-add multiplier over operands latched on load.
// With MULT_SINGLE_CYCLE_EN the product is formed in one step at load.
module mult_iter #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_load,
   input  logic               i_step,
   input  logic [WIDTH-1:0]   i_a,
   input  logic [WIDTH-1:0]   i_b,
   output logic [2*WIDTH-1:0] o_prod
);

`ifdef MULT_SINGLE_CYCLE_EN
   logic [2*WIDTH-1:0] r_acc;
   logic               w_unused_step;

   assign w_unused_step = i_step;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
      end else if (i_load) begin
         r_acc <= {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};
      end
   end
`else
   logic [2*WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0]   r_mplier;
   logic [2*WIDTH-1:0] r_acc;

   // One multiplier bit per step, LSB first, multiplicand shifting left.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
      end else if (i_load) begin
         r_mcand  <= {{WIDTH{1'b0}}, i_a};
         r_mplier <= i_b;
         r_acc    <= '0;
      end else if (i_step) begin
         if (r_mplier[0]) r_acc <= r_acc + r_mcand;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
      end
   end
`endif

   assign o_prod = r_acc;

endmodule

// File: rtl/mult_unit.sv
// Execute-stage multiply unit owning HI/LO; 33-cycle iterative by default,
// single-cycle when MULT_SINGLE_CYCLE_EN is defined.
module mult_unit
   import mult_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Start,
   input  logic             MULOp,
   input  logic [5:0]       Func,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic [WIDTH-1:0] MulOut,
   output logic             MulValid,
   output logic             Busy,
   output state_t           o_dbg_state
);

   state_t             r_state;
   logic [4:0]         r_cnt;
   op_class_t          r_class;
   logic               r_neg;
   logic [WIDTH-1:0]   r_hi, r_lo, r_mulout;
   logic               r_mulvalid, r_busy;

   logic               w_is_mul, w_signed, w_mthi, w_mtlo, w_accept, w_neg;
   op_class_t          w_class;
   logic [WIDTH-1:0]   w_op_a, w_op_b;
   logic [2*WIDTH-1:0] w_prod, w_prod_s, w_hilo;

   always_comb begin
      w_is_mul = 1'b0;
      w_signed = 1'b0;
      w_mthi   = 1'b0;
      w_mtlo   = 1'b0;
      w_class  = MC_MULT;
      if (!MULOp) begin
         case (Func)
            FUNC_MULT:  begin w_is_mul = 1'b1; w_signed = 1'b1; end
            FUNC_MULTU: w_is_mul = 1'b1;
            FUNC_MTHI:  w_mthi = 1'b1;
            FUNC_MTLO:  w_mtlo = 1'b1;
            default:    ;
         endcase
      end else begin
         case (Func)
            FUNC_MADD:  begin w_is_mul = 1'b1; w_signed = 1'b1; w_class = MC_MADD; end
            FUNC_MADDU: begin w_is_mul = 1'b1; w_class = MC_MADD; end
            FUNC_MSUB:  begin w_is_mul = 1'b1; w_signed = 1'b1; w_class = MC_MSUB; end
            FUNC_MSUBU: begin w_is_mul = 1'b1; w_class = MC_MSUB; end
            FUNC_MUL:   begin w_is_mul = 1'b1; w_signed = 1'b1; w_class = MC_MUL; end
            default:    ;
         endcase
      end
   end

   assign w_accept = Start && !r_busy && (r_state == IDLE);
   assign w_neg    = w_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
   assign w_op_a   = w_signed ? abs32(A) : A;
   assign w_op_b   = w_signed ? abs32(B) : B;

   mult_iter #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_accept && w_is_mul),
      .i_step (r_state == CALC),
      .i_a    (w_op_a),
      .i_b    (w_op_b),
      .o_prod (w_prod)
   );

   assign w_prod_s = r_neg ? (~w_prod + 64'd1) : w_prod;
   assign w_hilo   = {r_hi, r_lo};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_class    <= MC_MULT;
         r_neg      <= 1'b0;
         r_hi       <= '0;
         r_lo       <= '0;
         r_mulout   <= '0;
         r_mulvalid <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_mulvalid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (w_is_mul) begin
                     r_class <= w_class;
                     r_neg   <= w_neg;
                     r_busy  <= 1'b1;
                     r_cnt   <= '0;
`ifdef MULT_SINGLE_CYCLE_EN
                     r_state <= FIN;
`else
                     r_state <= CALC;
`endif
                  end else if (w_mthi) begin
                     r_hi <= A;
                  end else if (w_mtlo) begin
                     r_lo <= A;
                  end
               end
            end
            CALC: begin
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == 5'(ITER_COUNT - 1)) r_state <= FIN;
            end
            FIN: begin
               case (r_class)
                  MC_MULT: {r_hi, r_lo} <= w_prod_s;
                  MC_MADD: {r_hi, r_lo} <= w_hilo + w_prod_s;
                  MC_MSUB: {r_hi, r_lo} <= w_hilo - w_prod_s;
                  MC_MUL: begin
                     r_mulout   <= w_prod_s[WIDTH-1:0];
                     r_mulvalid <= 1'b1;
                  end
                  default: ;
               endcase
               r_busy  <= 1'b0;
               r_cnt   <= '0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign Hi          = r_hi;
   assign Lo          = r_lo;
   assign MulOut      = r_mulout;
   assign MulValid    = r_mulvalid;
   assign Busy        = r_busy;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed vector table, corner
// sequences (busy drops, reset abort, bad Func) and random ops vs a model.
module tb_mult_unit;

   localparam logic [5:0] F_MTHI  = 6'h11, F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18, F_MULTU = 6'h19;
   localparam logic [5:0] F_MADD  = 6'h00, F_MADDU = 6'h01;
   localparam logic [5:0] F_MUL   = 6'h02, F_MSUB  = 6'h04;
   localparam logic [5:0] F_MSUBU = 6'h05, F_ADD   = 6'h20;
`ifdef MULT_SINGLE_CYCLE_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 33;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        Start = 1'b0;
   logic        MULOp = 1'b0;
   logic [5:0]  Func = '0;
   logic [31:0] A = '0, B = '0;
   logic [31:0] Hi, Lo, MulOut;
   logic        MulValid, Busy;
   mult_pkg::state_t dbg_state;

   int total = 0;
   int bad   = 0;

   logic [63:0] m_hilo;
   logic [31:0] m_mul;

   typedef struct {
      logic        mulop;
      logic [5:0]  func;
      logic [31:0] a, b;
      logic [31:0] hi, lo, mul;
      logic        is_mul;
   } vec_t;

   vec_t vec[14];

   mult_unit dut (
      .clk(clk), .rst(rst), .Start(Start), .MULOp(MULOp), .Func(Func),
      .A(A), .B(B), .Hi(Hi), .Lo(Lo), .MulOut(MulOut),
      .MulValid(MulValid), .Busy(Busy), .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic mulop, input logic [5:0] func,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] hi, input logic [31:0] lo,
                               input logic [31:0] mul, input logic is_mul);
      vec_t v;
      v.mulop = mulop; v.func = func; v.a = a; v.b = b;
      v.hi = hi; v.lo = lo; v.mul = mul; v.is_mul = is_mul;
      return v;
   endfunction

   function automatic logic is_long(input logic mulop, input logic [5:0] func);
      return !(!mulop && (func == F_MTHI || func == F_MTLO));
   endfunction

   // Reference: plain 64-bit arithmetic on the architectural meaning of each op.
   task automatic model_apply(input logic mulop, input logic [5:0] func,
                              input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      logic [63:0] ps, pu;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ps = 64'(sa * sb);
      pu = {32'd0, a} * {32'd0, b};
      if (!mulop) begin
         case (func)
            F_MULT:  m_hilo = ps;
            F_MULTU: m_hilo = pu;
            F_MTHI:  m_hilo[63:32] = a;
            F_MTLO:  m_hilo[31:0] = a;
            default: ;
         endcase
      end else begin
         case (func)
            F_MADD:  m_hilo = m_hilo + ps;
            F_MADDU: m_hilo = m_hilo + pu;
            F_MSUB:  m_hilo = m_hilo - ps;
            F_MSUBU: m_hilo = m_hilo - pu;
            F_MUL:   m_mul = ps[31:0];
            default: ;
         endcase
      end
   endtask

   // Issues one op and returns #1 after the commit edge (or after E0 for MTHI/MTLO).
   task automatic run_op(input logic mulop, input logic [5:0] func,
                         input logic [31:0] a, input logic [31:0] b, input string tag);
      int n;
      @(negedge clk);
      Start = 1'b1; MULOp = mulop; Func = func; A = a; B = b;
      @(posedge clk); #1;
      Start = 1'b0; A = $urandom; B = $urandom;
      if (!is_long(mulop, func)) begin
         check({tag, " busy_mt"}, 64'(Busy), 64'd0);
      end else begin
         check({tag, " busy_e0"}, 64'(Busy), 64'd1);
         n = 0;
         while (Busy && n < 40) begin
            @(posedge clk); #1;
            n++;
         end
         check({tag, " latency"}, 64'(n), 64'(LAT));
      end
   endtask

   initial begin
      int n, mv_seen;
      logic [5:0]  funcs[9];
      logic        mops[9];
      logic [31:0] ra, rb;
      int k;

      vec[0]  = mk(0, F_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0);
      vec[1]  = mk(0, F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 0);
      vec[2]  = mk(0, F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, 0);
      vec[3]  = mk(0, F_MTLO,  32'h0,        32'h0,        32'h40000000, 32'h00000000, 0, 0);
      vec[4]  = mk(0, F_MTHI,  32'h1234,     32'h0,        32'h00001234, 32'h00000000, 0, 0);
      vec[5]  = mk(1, F_MADD,  32'd2,        32'd3,        32'h00001234, 32'h00000006, 0, 0);
      vec[6]  = mk(1, F_MUL,   32'h80000000, 32'hFFFFFFFF, 32'h00001234, 32'h00000006, 32'h80000000, 1);
      vec[7]  = mk(1, F_MUL,   32'd7,        32'hFFFFFFFD, 32'h00001234, 32'h00000006, 32'hFFFFFFEB, 1);
      vec[8]  = mk(0, F_MTHI,  32'h0,        32'h0,        32'h00000000, 32'h00000006, 0, 0);
      vec[9]  = mk(0, F_MTLO,  32'h0,        32'h0,        32'h00000000, 32'h00000000, 0, 0);
      vec[10] = mk(1, F_MSUB,  32'd1,        32'd7,        32'hFFFFFFFF, 32'hFFFFFFF9, 0, 0);
      vec[11] = mk(1, F_MADDU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFF7, 0, 0);
      vec[12] = mk(1, F_MSUBU, 32'd3,        32'd3,        32'h00000001, 32'hFFFFFFEE, 0, 0);
      vec[13] = mk(1, F_MADD,  32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFEC, 0, 0);

      // Clock/reset
      repeat (2) @(posedge clk);
      #1;
      check("rst Hi", 64'(Hi), 64'd0);
      check("rst Lo", 64'(Lo), 64'd0);
      check("rst MulOut", 64'(MulOut), 64'd0);
      check("rst MulValid", 64'(MulValid), 64'd0);
      check("rst Busy", 64'(Busy), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed table
      for (int i = 0; i < 14; i++) begin
         run_op(vec[i].mulop, vec[i].func, vec[i].a, vec[i].b, $sformatf("vec%0d", i));
         check($sformatf("vec%0d Hi", i), 64'(Hi), 64'(vec[i].hi));
         check($sformatf("vec%0d Lo", i), 64'(Lo), 64'(vec[i].lo));
         if (vec[i].is_mul) begin
            check($sformatf("vec%0d MulOut", i), 64'(MulOut), 64'(vec[i].mul));
            check($sformatf("vec%0d MulValid", i), 64'(MulValid), 64'd1);
            @(posedge clk); #1;
            check($sformatf("vec%0d MulValid_drop", i), 64'(MulValid), 64'd0);
         end else if (is_long(vec[i].mulop, vec[i].func)) begin
            check($sformatf("vec%0d MulValid", i), 64'(MulValid), 64'd0);
         end
      end

      // Unknown Func (ADD) is ignored
      @(negedge clk);
      Start = 1'b1; MULOp = 1'b0; Func = F_ADD; A = 32'hAAAA5555; B = 32'h3;
      @(posedge clk); #1;
      Start = 1'b0;
      check("add Busy", 64'(Busy), 64'd0);
      check("add HiLo", {Hi, Lo}, 64'h00000001_FFFFFFEC);

      // Start and MTHI while busy are dropped
      @(negedge clk);
      Start = 1'b1; MULOp = 1'b0; Func = F_MULT; A = 32'd5; B = 32'd6;
      @(posedge clk); #1;
      A = 32'd9; B = 32'd9;
`ifndef MULT_SINGLE_CYCLE_EN
      @(posedge clk); #1;
      Func = F_MTHI; A = 32'hDEAD;
`endif
      @(posedge clk); #1;
      Start = 1'b0;
`ifndef MULT_SINGLE_CYCLE_EN
      check("busy Hi_stable", {Hi, Lo}, 64'h00000001_FFFFFFEC);
`endif
      n = 0;
      while (Busy && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("busy HiLo", {Hi, Lo}, 64'd30);
      @(posedge clk); #1;
      check("busy no_restart", 64'(Busy), 64'd0);

      // Reset in the middle of CALC
      run_op(0, F_MTHI, 32'h55, 32'h0, "pre_abort");
      @(negedge clk);
      Start = 1'b1; MULOp = 1'b0; Func = F_MULT; A = 32'd3; B = 32'd3;
      @(posedge clk); #1;
      Start = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort Busy", 64'(Busy), 64'd0);
      check("abort HiLo", {Hi, Lo}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      mv_seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (MulValid || Busy) mv_seen++;
      end
      check("abort quiet", 64'(mv_seen), 64'd0);
      check("abort HiLo_after", {Hi, Lo}, 64'd0);

      // Random ops against the reference model
      funcs = '{F_MULT, F_MULTU, F_MTHI, F_MTLO, F_MADD, F_MADDU, F_MSUB, F_MSUBU, F_MUL};
      mops  = '{1'b0,   1'b0,    1'b0,   1'b0,   1'b1,   1'b1,    1'b1,   1'b1,    1'b1};
      m_hilo = 64'd0;
      m_mul  = 32'd0;
      for (int r = 0; r < 24; r++) begin
         k = $urandom_range(0, 8);
         case ($urandom_range(0, 3))
            0: ra = 32'h80000000;
            1: ra = 32'hFFFFFFFF;
            default: ra = $urandom;
         endcase
         rb = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
         model_apply(mops[k], funcs[k], ra, rb);
         run_op(mops[k], funcs[k], ra, rb, $sformatf("rnd%0d", r));
         check($sformatf("rnd%0d HiLo", r), {Hi, Lo}, m_hilo);
         if (mops[k] && funcs[k] == F_MUL) begin
            check($sformatf("rnd%0d MulOut", r), 64'(MulOut), 64'(m_mul));
            check($sformatf("rnd%0d MulValid", r), 64'(MulValid), 64'd1);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
